// File: rtl/cmac_pkt_gen_if.sv
// rtl/cmac_pkt_gen_if.sv - per-port AXI-Stream bundle for the CMAC packet generator
interface cmac_pkt_gen_if #(
  parameter int NUM_PORT = 1,
  parameter int DATA_W   = 512
);
  localparam int BYTES = DATA_W / 8;

  logic [NUM_PORT-1:0]        m_axis_tvalid;
  logic [NUM_PORT-1:0]        m_axis_tready;
  logic [NUM_PORT-1:0]        m_axis_tlast;
  logic [NUM_PORT-1:0]        m_axis_tuser_err;
  logic [NUM_PORT*DATA_W-1:0] m_axis_tdata;
  logic [NUM_PORT*BYTES-1:0]  m_axis_tkeep;

  modport master (
    output m_axis_tvalid, m_axis_tlast, m_axis_tuser_err, m_axis_tdata, m_axis_tkeep,
    input  m_axis_tready
  );

  modport slave (
    input  m_axis_tvalid, m_axis_tlast, m_axis_tuser_err, m_axis_tdata, m_axis_tkeep,
    output m_axis_tready
  );
endinterface

// File: rtl/cmac_pkt_gen.sv
// rtl/cmac_pkt_gen.sv - multi-port AXI-Stream test packet generator
module cmac_pkt_gen #(
  parameter int DATA_W      = 512,
  parameter int NUM_PORT    = 1,
  parameter int MIN_PKT_LEN = 64,
  parameter int MAX_PKT_LEN = 1518
) (
  input  logic                     cmac_clk,
  input  logic                     cmac_rstn,
  input  logic [NUM_PORT-1:0]      start,
  input  logic [NUM_PORT-1:0]      stop,
  input  logic [15:0]              cfg_pkt_len,
  input  logic [15:0]              cfg_pkt_count,
  input  logic [7:0]               cfg_ipg,
  input  logic [7:0]               cfg_err_every,
  cmac_pkt_gen_if.master           axis,
  output logic [NUM_PORT-1:0]      busy,
  output logic [NUM_PORT-1:0]      done,
  output logic [NUM_PORT*16-1:0]   pkt_sent
);
  localparam int BYTES = DATA_W / 8;
  localparam int BW    = $clog2(BYTES);

  typedef enum logic [1:0] {IDLE, SEND, GAP, FIN} state_t;

  // Starts are ignored on the first edge after reset release.
  logic rdy;
  always_ff @(posedge cmac_clk or negedge cmac_rstn) begin
    if (!cmac_rstn) rdy <= 1'b0;
    else            rdy <= 1'b1;
  end

  logic [15:0] len_clamp;
  logic [15:0] beats_req;
  always_comb begin
    len_clamp = cfg_pkt_len;
    if (cfg_pkt_len < 16'(MIN_PKT_LEN))      len_clamp = 16'(MIN_PKT_LEN);
    else if (cfg_pkt_len > 16'(MAX_PKT_LEN)) len_clamp = 16'(MAX_PKT_LEN);
  end
  assign beats_req = (len_clamp + 16'(BYTES - 1)) >> BW;

  for (genvar p = 0; p < NUM_PORT; p++) begin : g_port
    state_t            state, state_nxt;
    logic [15:0]       beats_q, beat, sent, count_q;
    logic [7:0]        ipg_q, gap_cnt, err_every_q, err_cnt, beat_off;
    logic [BW-1:0]     rem_q;
    logic              stop_seen, valid, last, xfer, run_end, err;
    logic              busy_c, done_c;
    logic [DATA_W-1:0] data;
    logic [BYTES-1:0]  keep, keep_last;

    assign last     = (beat == beats_q - 16'd1);
    assign xfer     = (state == SEND) && axis.m_axis_tready[p];
    assign err      = last && (err_every_q != 8'd0) && (err_cnt == 8'd1);
    assign run_end  = (sent + 16'd1 == count_q) || stop_seen || stop[p];
    assign beat_off = 8'(beat << BW);
    assign keep_last = (rem_q == '0) ? '1 : ~({BYTES{1'b1}} << rem_q);

    always_comb begin
      state_nxt = state;
      valid     = 1'b0;
      busy_c    = 1'b0;
      done_c    = 1'b0;
      case (state)
        IDLE: if (rdy && start[p]) state_nxt = (cfg_pkt_count == 16'd0) ? FIN : SEND;
        SEND: begin
          valid  = 1'b1;
          busy_c = 1'b1;
          if (xfer && last) state_nxt = run_end ? FIN : ((ipg_q != 8'd0) ? GAP : SEND);
        end
        GAP: begin
          busy_c = 1'b1;
          if (stop[p])                state_nxt = FIN;
          else if (gap_cnt == 8'd1)   state_nxt = SEND;
        end
        FIN: begin
          done_c    = 1'b1;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end

    always_ff @(posedge cmac_clk or negedge cmac_rstn) begin
      if (!cmac_rstn) begin
        state       <= IDLE;
        beats_q     <= '0;
        beat        <= '0;
        sent        <= '0;
        count_q     <= '0;
        ipg_q       <= '0;
        gap_cnt     <= '0;
        err_every_q <= '0;
        err_cnt     <= '0;
        rem_q       <= '0;
        stop_seen   <= 1'b0;
      end else begin
        state <= state_nxt;
        case (state)
          IDLE: if (rdy && start[p]) begin
            beats_q     <= beats_req;
            rem_q       <= len_clamp[BW-1:0];
            count_q     <= cfg_pkt_count;
            ipg_q       <= cfg_ipg;
            err_every_q <= cfg_err_every;
            err_cnt     <= cfg_err_every;
            sent        <= '0;
            beat        <= '0;
            stop_seen   <= stop[p];
          end
          SEND: begin
            if (stop[p]) stop_seen <= 1'b1;
            if (xfer) begin
              if (last) begin
                beat    <= '0;
                sent    <= sent + 16'd1;
                gap_cnt <= ipg_q;
                // Reloading down-counter flags every err_every-th packet.
                err_cnt <= (err_cnt <= 8'd1) ? err_every_q : err_cnt - 8'd1;
              end else begin
                beat <= beat + 16'd1;
              end
            end
          end
          GAP:     gap_cnt <= gap_cnt - 8'd1;
          default: ;
        endcase
      end
    end

    always_comb begin
      data = '0;
      if (valid)
        for (int k = 0; k < BYTES; k++) data[k*8 +: 8] = sent[7:0] + beat_off + 8'(k);
    end
    assign keep = valid ? (last ? keep_last : '1) : '0;

    assign axis.m_axis_tvalid[p]                  = valid;
    assign axis.m_axis_tlast[p]                   = valid && last;
    assign axis.m_axis_tuser_err[p]               = valid && err;
    assign axis.m_axis_tdata[p*DATA_W +: DATA_W]  = data;
    assign axis.m_axis_tkeep[p*BYTES +: BYTES]    = keep;
    assign busy[p]                                = busy_c;
    assign done[p]                                = done_c;
    assign pkt_sent[p*16 +: 16]                   = sent;
  end
endmodule

// File: tb/tb_cmac_pkt_gen.sv
// tb/tb_cmac_pkt_gen.sv - directed self-checking bench for cmac_pkt_gen
module tb_cmac_pkt_gen;
  localparam int DW = 512;
  localparam int NP = 2;
  localparam int BY = DW / 8;

  logic            clk  = 1'b0;
  logic            rstn = 1'b0;
  logic [NP-1:0]   start, stop, busy, done;
  logic [15:0]     len, cnt;
  logic [7:0]      ipg, erre;
  logic [NP*16-1:0] pkt_sent;
  int nvec = 0;
  int nerr = 0;

  logic [DW-1:0] q_data[$];
  logic [BY-1:0] q_keep[$];
  logic          q_last[$];
  logic          q_err[$];
  int            q_cyc[$];
  int            done_cyc;
  logic          run_fin;

  cmac_pkt_gen_if #(.NUM_PORT(NP), .DATA_W(DW)) axis ();

  cmac_pkt_gen #(.DATA_W(DW), .NUM_PORT(NP), .MIN_PKT_LEN(64), .MAX_PKT_LEN(1518)) dut (
    .cmac_clk(clk), .cmac_rstn(rstn), .start(start), .stop(stop),
    .cfg_pkt_len(len), .cfg_pkt_count(cnt), .cfg_ipg(ipg), .cfg_err_every(erre),
    .axis(axis), .busy(busy), .done(done), .pkt_sent(pkt_sent)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] pat(input int n, input int b);
    logic [DW-1:0] r;
    for (int k = 0; k < BY; k++) r[k*8 +: 8] = 8'((n + b * BY + k) % 256);
    return r;
  endfunction

  // Runs port 0 from start to done, recording every transferred beat.
  task automatic run0(input bit rnd, input int budget);
    logic          held;
    logic [DW-1:0] hd;
    logic [BY+2:0] hc;
    q_data.delete(); q_keep.delete(); q_last.delete(); q_err.delete(); q_cyc.delete();
    run_fin = 1'b0;
    done_cyc = -1;
    held = 1'b0;
    hd = '0;
    hc = '0;
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    for (int c = 0; c < budget && !run_fin; c++) begin
      if (done[0]) begin
        run_fin  = 1'b1;
        done_cyc = c;
      end else begin
        if (held) begin
          chk("stall_data", axis.m_axis_tdata[DW-1:0], hd);
          chk("stall_ctrl", {axis.m_axis_tvalid[0], axis.m_axis_tlast[0],
                             axis.m_axis_tuser_err[0], axis.m_axis_tkeep[BY-1:0]}, hc);
        end
        axis.m_axis_tready[0] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (axis.m_axis_tvalid[0] && axis.m_axis_tready[0]) begin
          q_data.push_back(axis.m_axis_tdata[DW-1:0]);
          q_keep.push_back(axis.m_axis_tkeep[BY-1:0]);
          q_last.push_back(axis.m_axis_tlast[0]);
          q_err.push_back(axis.m_axis_tuser_err[0]);
          q_cyc.push_back(c);
        end
        held = axis.m_axis_tvalid[0] && !axis.m_axis_tready[0];
        hd   = axis.m_axis_tdata[DW-1:0];
        hc   = {axis.m_axis_tvalid[0], axis.m_axis_tlast[0],
                axis.m_axis_tuser_err[0], axis.m_axis_tkeep[BY-1:0]};
        step();
      end
    end
    axis.m_axis_tready[0] = 1'b1;
    chk("run_done_seen", run_fin, 1'b1);
    chk("done_busy_low", busy[0], 1'b0);
    step();
    chk("done_pulse_end", done[0], 1'b0);
  endtask

  initial begin
    logic [BY-1:0] acc;
    start = '0; stop = '0; len = 16'd64; cnt = 16'd1; ipg = 8'd0; erre = 8'd0;
    axis.m_axis_tready = '1;

    #12;
    chk("rst_tvalid", axis.m_axis_tvalid, 0);
    chk("rst_ctrl", {axis.m_axis_tlast, axis.m_axis_tuser_err, busy, done}, 0);
    chk("rst_tdata", axis.m_axis_tdata[DW-1:0], 0);
    chk("rst_tkeep", axis.m_axis_tkeep, 0);
    chk("rst_pkt_sent", pkt_sent, 0);

    @(posedge clk); #1;
    rstn = 1'b1;
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    chk("early_start_ignored", {busy[0], axis.m_axis_tvalid[0]}, 2'b00);

    // Single minimum-size packet.
    run0(1'b0, 20);
    chk("p64_beats", q_data.size(), 1);
    chk("p64_first_cycle", q_cyc[0], 0);
    chk("p64_keep", q_keep[0], {BY{1'b1}});
    chk("p64_last", q_last[0], 1'b1);
    chk("p64_data", q_data[0], pat(0, 0));
    chk("p64_done_next", done_cyc, 1);
    chk("p64_pkt_sent", pkt_sent[15:0], 16'd1);

    // Two-beat packets separated by three idle cycles.
    len = 16'd65; cnt = 16'd2; ipg = 8'd3;
    run0(1'b0, 40);
    chk("p65_beats", q_data.size(), 4);
    chk("p65_keep_b1", q_keep[1], 64'h1);
    chk("p65_b1_byte0", q_data[1][7:0], 8'h40);
    chk("p65_ipg", q_cyc[2] - q_cyc[1], 4);
    chk("p65_p1_byte0", q_data[2][7:0], 8'h01);
    chk("p65_lasts", {q_last[0], q_last[1], q_last[2], q_last[3]}, 4'b0101);
    chk("p65_pkt_sent", pkt_sent[15:0], 16'd2);

    // Length clamping at both ends.
    len = 16'd10; cnt = 16'd1; ipg = 8'd0;
    run0(1'b0, 20);
    chk("clamp_lo_beats", q_data.size(), 1);
    chk("clamp_lo_keep", q_keep[0], {BY{1'b1}});
    len = 16'd2000;
    run0(1'b0, 60);
    chk("clamp_hi_beats", q_data.size(), 24);
    chk("clamp_hi_keep", q_keep[23], 64'h0000_3FFF_FFFF_FFFF);
    chk("clamp_hi_last", {q_last[22], q_last[23]}, 2'b01);

    // Random back-pressure: every beat exactly once, in order.
    len = 16'd200; cnt = 16'd4; ipg = 8'd1;
    run0(1'b1, 300);
    chk("bp_transfers", q_data.size(), 16);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("bp_data_%0d", i), q_data[i], pat(i / 4, i % 4));
      chk($sformatf("bp_keep_%0d", i), q_keep[i], (i % 4 == 3) ? 64'hFF : {BY{1'b1}});
    end

    // Error injection every third packet, then disabled.
    len = 16'd64; cnt = 16'd6; ipg = 8'd0; erre = 8'd3;
    run0(1'b0, 30);
    chk("err3_beats", q_data.size(), 6);
    chk("err3_flags", {q_err[0], q_err[1], q_err[2], q_err[3], q_err[4], q_err[5]}, 6'b001001);
    erre = 8'd0;
    run0(1'b0, 30);
    acc = '0;
    for (int i = 0; i < q_err.size(); i++) acc[i] = q_err[i];
    chk("err0_flags", acc, 0);

    // Two independent ports; stop on port 1 mid-packet.
    len = 16'd2000; cnt = 16'd3;
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    repeat (4) step();
    len = 16'd200; cnt = 16'd5;
    start[1] = 1'b1;
    step();
    start[1] = 1'b0;
    step();
    stop[1] = 1'b1;
    step();
    stop[1] = 1'b0;
    for (int c = 0; c < 10 && !done[1]; c++) step();
    chk("p1_done", done[1], 1'b1);
    chk("p1_pkt_sent", pkt_sent[31:16], 16'd1);
    chk("p1_busy_low", busy[1], 1'b0);
    chk("p0_unaffected", {busy[0], axis.m_axis_tvalid[0]}, 2'b11);
    chk("p0_data_b9", axis.m_axis_tdata[DW-1:0], pat(0, 9));

    #3;
    rstn = 1'b0;
    #1;
    chk("arst_tvalid", axis.m_axis_tvalid, 0);
    chk("arst_pkt_sent", pkt_sent, 0);
    chk("arst_busy", busy, 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    step();
    step();
    chk("post_rst_idle", {busy, axis.m_axis_tvalid}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
